// File: rtl/regs_wb_arb.sv
// Round-robin write-back arbiter: up to two non-conflicting register writes per cycle,
// driven from a registered output stage. Define REGS_WB_ARB_PERF_EN to add perf_conflict.
module regs_wb_arb #(
  parameter int NREQ  = 4,
  parameter int NPORT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_addr,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wen0,
  output logic                 wen1,
  output logic [2:0]           waddr0,
  output logic [2:0]           waddr1,
  output logic [15:0]          wdata0,
  output logic [15:0]          wdata1,
  output logic [7:0]           busy
`ifdef REGS_WB_ARB_PERF_EN
  ,
  output logic [15:0]          perf_conflict
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] MAX_GRANTS = 2'(NPORT);

  logic [2:0]    addr_arr [NREQ];
  logic [15:0]   data_arr [NREQ];

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] sel;
  logic [PW-1:0] last_sel;
  logic [PW:0]   scan_sum;
  logic [PW:0]   next_sum;

  logic [NREQ-1:0] grant;
  logic [1:0]      n_grant;
  logic            g0_valid;
  logic            g1_valid;
  logic [2:0]      g0_addr;
  logic [2:0]      g1_addr;
  logic [15:0]     g0_data;
  logic [15:0]     g1_data;
`ifdef REGS_WB_ARB_PERF_EN
  logic            conflict;
`endif

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[3*gi +: 3];
    assign data_arr[gi] = req_data[16*gi +: 16];
  end

  // Scan from ptr; the first grant takes port 0, a later one with a different address takes port 1.
  always_comb begin
    grant    = '0;
    n_grant  = '0;
    g0_valid = 1'b0;
    g1_valid = 1'b0;
    g0_addr  = '0;
    g1_addr  = '0;
    g0_data  = '0;
    g1_data  = '0;
    sel      = '0;
    scan_sum = '0;
    last_sel = ptr;
`ifdef REGS_WB_ARB_PERF_EN
    conflict = 1'b0;
`endif
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_sum = {1'b0, ptr} + (PW+1)'(k);
        if (scan_sum >= (PW+1)'(NREQ)) begin
          scan_sum = scan_sum - (PW+1)'(NREQ);
        end
        sel = scan_sum[PW-1:0];
        if (req_valid[sel] && (n_grant < MAX_GRANTS)) begin
          if (g0_valid && (addr_arr[sel] == g0_addr)) begin
`ifdef REGS_WB_ARB_PERF_EN
            conflict = 1'b1;
`endif
          end else begin
            grant[sel] = 1'b1;
            last_sel   = sel;
            if (!g0_valid) begin
              g0_valid = 1'b1;
              g0_addr  = addr_arr[sel];
              g0_data  = data_arr[sel];
            end else begin
              g1_valid = 1'b1;
              g1_addr  = addr_arr[sel];
              g1_data  = data_arr[sel];
            end
            n_grant = n_grant + 2'd1;
          end
        end
      end
    end
  end

  // Next highest priority is the requester just after the last one granted.
  always_comb begin
    next_sum = {1'b0, last_sel} + (PW+1)'(1);
    if (next_sum >= (PW+1)'(NREQ)) begin
      next_sum = '0;
    end
    ptr_next = next_sum[PW-1:0];
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      wen0   <= 1'b0;
      wen1   <= 1'b0;
      waddr0 <= '0;
      waddr1 <= '0;
      wdata0 <= '0;
      wdata1 <= '0;
    end else begin
      wen0 <= g0_valid;
      wen1 <= g1_valid;
      if (g0_valid) begin
        waddr0 <= g0_addr;
        wdata0 <= g0_data;
        ptr    <= ptr_next;
      end
      if (g1_valid) begin
        waddr1 <= g1_addr;
        wdata1 <= g1_data;
      end
    end
  end

  always_comb begin
    busy = '0;
    if (wen0) busy[waddr0] = 1'b1;
    if (wen1) busy[waddr1] = 1'b1;
  end

`ifdef REGS_WB_ARB_PERF_EN
  // Saturating count of cycles in which a valid requester lost out to a same-register grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict <= '0;
    end else if (conflict && (perf_conflict != 16'hFFFF)) begin
      perf_conflict <= perf_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regs_wb_arb.sv
// Self-checking bench for regs_wb_arb: hand-derived vector table, backpressure sequence,
// and randomized traffic compared against a scan-list reference model.
module tb_regs_wb_arb;
  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [3*NREQ-1:0]   req_addr;
  logic [16*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                wen0, wen1;
  logic [2:0]          waddr0, waddr1;
  logic [15:0]         wdata0, wdata1;
  logic [7:0]          busy;
`ifdef REGS_WB_ARB_PERF_EN
  logic [15:0]         perf_conflict;
`endif

  always #5 clk = ~clk;

  regs_wb_arb #(.NREQ(NREQ), .NPORT(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .wen0(wen0),
    .wen1(wen1),
    .waddr0(waddr0),
    .waddr1(waddr1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .busy(busy)
`ifdef REGS_WB_ARB_PERF_EN
    ,
    .perf_conflict(perf_conflict)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: what the register file ports should show
  int              m_ptr;
  logic            m_wen0, m_wen1;
  logic [2:0]      m_waddr0, m_waddr1;
  logic [15:0]     m_wdata0, m_wdata1;
  int              m_perf;

  logic [NREQ-1:0] exp_grant;
  int              exp_sel0, exp_sel1, exp_n;
  bit              exp_conf;

  typedef struct {
    logic               rst;
    logic [NREQ-1:0]    valid;
    logic [3*NREQ-1:0]  addr;
    logic [16*NREQ-1:0] data;
    logic [NREQ-1:0]    exp_ready;
  } vec_t;

  vec_t vecs [14];

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [2:0] addr_of(input logic [3*NREQ-1:0] a, input int i);
    logic [3*NREQ-1:0] t;
    t = a >> (3*i);
    return t[2:0];
  endfunction

  function automatic logic [15:0] data_of(input logic [16*NREQ-1:0] d, input int i);
    logic [16*NREQ-1:0] t;
    t = d >> (16*i);
    return t[15:0];
  endfunction

  function automatic logic [3*NREQ-1:0] set_addr(input logic [3*NREQ-1:0] a, input int i,
                                                 input logic [2:0] x);
    return (a & ~((3*NREQ)'(7) << (3*i))) | ((3*NREQ)'(x) << (3*i));
  endfunction

  function automatic logic [16*NREQ-1:0] set_data(input logic [16*NREQ-1:0] d, input int i,
                                                  input logic [15:0] x);
    return (d & ~((16*NREQ)'(16'hFFFF) << (16*i))) | ((16*NREQ)'(x) << (16*i));
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Walk the priority list from p, keeping a list of addresses already granted this cycle
  function automatic void model_arb(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] a,
                                    input int p, output logic [NREQ-1:0] g, output int s0,
                                    output int s1, output int n, output bit conf);
    logic [2:0] taken [$];
    g = '0; s0 = 0; s1 = 0; n = 0; conf = 0;
    for (int k = 0; k < NREQ; k++) begin
      int  i;
      bit  clash;
      i = (p + k) % NREQ;
      if (!bit_of(v, i) || n == 2) continue;
      clash = 0;
      foreach (taken[j]) if (taken[j] == addr_of(a, i)) clash = 1;
      if (clash) begin
        conf = 1;
      end else begin
        g = g | onehot(i);
        if (n == 0) s0 = i; else s1 = i;
        n++;
        taken.push_back(addr_of(a, i));
      end
    end
  endfunction

  function automatic vec_t mk(input logic r, input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] a,
                              input logic [16*NREQ-1:0] d, input logic [NREQ-1:0] e);
    vec_t x;
    x.rst = r; x.valid = v; x.addr = a; x.data = d; x.exp_ready = e;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v,
                               input logic [3*NREQ-1:0] a, input logic [16*NREQ-1:0] d);
    rst       = r;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #2;
  endtask

  task automatic checkOutput();
    logic [7:0] exp_busy;
    if (rst) begin
      exp_grant = '0; exp_sel0 = 0; exp_sel1 = 0; exp_n = 0; exp_conf = 0;
    end else begin
      model_arb(req_valid, req_addr, m_ptr, exp_grant, exp_sel0, exp_sel1, exp_n, exp_conf);
    end
    exp_busy = (m_wen0 ? (8'd1 << m_waddr0) : 8'd0) | (m_wen1 ? (8'd1 << m_waddr1) : 8'd0);
    check("req_ready", 32'(req_ready), 32'(exp_grant));
    check("wen0",      32'(wen0),      32'(m_wen0));
    check("wen1",      32'(wen1),      32'(m_wen1));
    check("waddr0",    32'(waddr0),    32'(m_waddr0));
    check("waddr1",    32'(waddr1),    32'(m_waddr1));
    check("wdata0",    32'(wdata0),    32'(m_wdata0));
    check("wdata1",    32'(wdata1),    32'(m_wdata1));
    check("busy",      32'(busy),      32'(exp_busy));
    if (wen0 === 1'b1 && wen1 === 1'b1) check("distinct_waddr", 32'(waddr0 != waddr1), 32'd1);
`ifdef REGS_WB_ARB_PERF_EN
    check("perf_conflict", 32'(perf_conflict), 32'(m_perf));
`endif
  endtask

  // Clock edge: the model latches the grants it predicted for the cycle just ended
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_wen0 = 0; m_wen1 = 0; m_waddr0 = 0; m_waddr1 = 0;
      m_wdata0 = 0; m_wdata1 = 0; m_perf = 0;
    end else begin
      m_wen0 = (exp_n >= 1);
      m_wen1 = (exp_n >= 2);
      if (exp_n >= 1) begin
        m_waddr0 = addr_of(req_addr, exp_sel0);
        m_wdata0 = data_of(req_data, exp_sel0);
        m_ptr    = (((exp_n == 2) ? exp_sel1 : exp_sel0) + 1) % NREQ;
      end
      if (exp_n >= 2) begin
        m_waddr1 = addr_of(req_addr, exp_sel1);
        m_wdata1 = data_of(req_data, exp_sel1);
      end
      if (exp_conf && m_perf < 65535) m_perf++;
    end
    #1;
  endtask

  initial begin
    logic [3*NREQ-1:0]  a1234, aconf, a77, a14, ra;
    logic [16*NREQ-1:0] dbase, rd;
    logic [NREQ-1:0]    rv;
    logic [15:0]        d2;
    int                 cnt_beef, cnt_1234;

    m_ptr = 0; m_wen0 = 0; m_wen1 = 0; m_waddr0 = 0; m_waddr1 = 0;
    m_wdata0 = 0; m_wdata1 = 0; m_perf = 0;
    exp_grant = '0; exp_sel0 = 0; exp_sel1 = 0; exp_n = 0; exp_conf = 0;

    a1234 = {3'd4, 3'd3, 3'd2, 3'd1};
    aconf = {3'd0, 3'd6, 3'd5, 3'd5};
    a77   = {3'd7, 3'd0, 3'd0, 3'd7};
    a14   = {3'd4, 3'd0, 3'd0, 3'd1};
    dbase = {16'hD333, 16'hC222, 16'hB111, 16'hA000};

    vecs[0]  = mk(1'b1, 4'hF, a1234, dbase, 4'b0000);
    vecs[1]  = mk(1'b1, 4'hF, a1234, dbase, 4'b0000);
    vecs[2]  = mk(1'b0, 4'hF, a1234, dbase, 4'b0011);
    vecs[3]  = mk(1'b0, 4'hF, a1234, dbase, 4'b1100);
    vecs[4]  = mk(1'b0, 4'b0111, aconf, dbase, 4'b0101);
    vecs[5]  = mk(1'b0, 4'b0010, aconf, dbase, 4'b0010);
    vecs[6]  = mk(1'b0, 4'b1001, a77, dbase, 4'b1000);
    vecs[7]  = mk(1'b0, 4'b1001, a77, dbase, 4'b0001);
    vecs[8]  = mk(1'b0, 4'b1001, a77, dbase, 4'b1000);
    vecs[9]  = mk(1'b0, 4'b1001, a77, dbase, 4'b0001);
    vecs[10] = mk(1'b1, 4'hF, a1234, dbase, 4'b0000);
    vecs[11] = mk(1'b0, 4'hF, a1234, dbase, 4'b0011);
    vecs[12] = mk(1'b0, 4'b1001, a14, dbase, 4'b1001);
    vecs[13] = mk(1'b0, 4'b1001, a14, dbase, 4'b1001);

    applyStimulus(1'b1, '0, '0, '0);
    advance();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].addr,
                    vecs[i].data ^ {NREQ{16'(i)}});
      checkOutput();
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      advance();
    end

    // Backpressure: req2 waits behind req0/req1, then sends 0xBEEF and 0x1234 once each
    applyStimulus(1'b1, '0, '0, '0);
    checkOutput();
    advance();
    rv = 4'b0111;
    ra = {3'd0, 3'd3, 3'd2, 3'd1};
    d2 = 16'hBEEF;
    cnt_beef = 0;
    cnt_1234 = 0;
    for (int c = 0; c < 10; c++) begin
      rd = set_data({16'h0, 16'h0, 16'h5151, 16'h5050}, 2, d2);
      applyStimulus(1'b0, rv, ra, rd);
      checkOutput();
      if (wen0 === 1'b1 && waddr0 == 3'd3 && wdata0 == 16'hBEEF) cnt_beef++;
      if (wen1 === 1'b1 && waddr1 == 3'd3 && wdata1 == 16'hBEEF) cnt_beef++;
      if (wen0 === 1'b1 && waddr0 == 3'd3 && wdata0 == 16'h1234) cnt_1234++;
      if (wen1 === 1'b1 && waddr1 == 3'd3 && wdata1 == 16'h1234) cnt_1234++;
      if (bit_of(exp_grant, 2)) begin
        if (d2 == 16'hBEEF) d2 = 16'h1234;
        else rv = rv & ~onehot(2);
      end
      rv = rv & ~(exp_grant & 4'b0011);
      advance();
    end
    check("bp_beef_count", 32'(cnt_beef), 32'd1);
    check("bp_1234_count", 32'(cnt_1234), 32'd1);

    // Randomized traffic obeying the hold-until-ready protocol, with occasional resets
    rv = '0;
    ra = '0;
    rd = '0;
    for (int c = 0; c < 400; c++) begin
      logic rr;
      for (int i = 0; i < NREQ; i++) begin
        if (!bit_of(rv, i) && ($urandom_range(0, 2) != 0)) begin
          rv = rv | onehot(i);
          ra = set_addr(ra, i, 3'($urandom_range(0, 5)));
          rd = set_data(rd, i, 16'($urandom));
        end
      end
      rr = ($urandom_range(0, 39) == 0);
      applyStimulus(rr, rv, ra, rd);
      checkOutput();
      rv = rv & ~exp_grant;
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
